sram_cluster_ctrl: RTL and testbench
====================================

Name: sram_cluster_ctrl

Overview:
- Request-side controller for one 4-bank SRAM cluster (banks A, B, C, D, 8 bits each).
- Accepts fabric read/write requests in x8, x16 or x32 mode and drives the per-bank chip-select, write-enable, address and data-in pins.
- Tracks read latency and drives csb_out_A..D plus rd_valid for the downstream cluster output mux, so the mux steers returned bytes onto d_fabric.

Parameters:
ADDR_W, 8, per-bank word address width
READ_LAT, 1, cycles from the SRAM sampling edge to valid dout; legal range 1..7

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  request valid
req_ready  out  1  controller can accept a request
req_we  in  1  1 = write, 0 = read
req_mode  in  2  0 = x8, 1 = x16, 2 = x32, 3 = reserved
req_addr  in  ADDR_W+2  [ADDR_W+1:2] bank word address; [1:0] byte lane
req_wdata  in  32  write data, right-aligned for x8/x16
csb_A, csb_B, csb_C, csb_D  out  1 each  bank chip select, active-low
web_A, web_B, web_C, web_D  out  1 each  bank write enable, active-low
addr_sram  out  ADDR_W  shared bank address
din_A, din_B, din_C, din_D  out  8 each  bank write data
csb_out_A, csb_out_B, csb_out_C, csb_out_D  out  1 each  lane-select to output mux, active-high one-hot or pair
rd_valid  out  1  read data valid on mux output this cycle
wr_ack  out  1  write issued pulse
err  out  1  request rejected pulse

Behaviour:
- FSM states: IDLE, ISSUE, WAIT. req_ready = 1 only in IDLE and not in rst.
- Handshake cycle = cycle 0, when req_valid & req_ready are sampled at the edge. All request fields are registered at that edge.
- Lane mask, ordered {A,B,C,D}:
  - x8: addr[1:0] 0/1/2/3 -> 1000/0100/0010/0001.
  - x16: addr[1:0]=00 -> 1100; addr[1:0]=10 -> 0011.
  - x32: addr[1:0]=00 -> 1111.
- Illegal requests: x16 with odd addr, x32 with addr[1:0]!=00, or mode 3.
  - Go to ISSUE with no bank selected.
  - err=1 in cycle 1; return to IDLE in cycle 2.
- Write data lanes:
  - x8: wdata[7:0] -> selected bank.
  - x16: wdata[15:8] -> A or C; wdata[7:0] -> B or D.
  - x32: [31:24] A, [23:16] B, [15:8] C, [7:0] D.
  - Unselected din = 0.
- ISSUE (cycle 1):
  - csb_x = 0 for mask lanes, 1 otherwise.
  - web_x = 0 for mask lanes on write, 1 otherwise.
  - addr_sram = registered addr[ADDR_W+1:2].
- Write completion: wr_ack=1 in cycle 1; next state IDLE, so req_ready=1 in cycle 2.
- Read completion:
  - ISSUE -> WAIT, with the down-counter loaded to READ_LAT.
  - In the final WAIT cycle (cycle 1+READ_LAT): rd_valid=1 and csb_out_A..D = mask.
  - Next state IDLE (cycle 2+READ_LAT).
- Outside ISSUE: csb_x=1, web_x=1, din_x=0, and addr_sram holds its last value.
- Outside the final read cycle: csb_out_A..D = 0000 and rd_valid = 0.
- wr_ack, err and rd_valid are single-cycle pulses and mutually exclusive.
- req_valid while not ready: ignored. Requester holds the request; no fields are sampled.
- Reset values:
  - FSM = IDLE, counter = 0.
  - csb_A..D = 1, web_A..D = 1, addr_sram = 0, din_A..D = 0.
  - csb_out_A..D = 0, rd_valid = 0, wr_ack = 0, err = 0, req_ready = 0.
  - req_ready = 1 in the first cycle after rst falls.
- rst asserted in ISSUE or WAIT:
  - Next cycle is fully reset state; the in-flight read produces no rd_valid.
  - An in-flight write whose ISSUE edge coincides with rst is still sampled by the SRAM; no wr_ack is produced.
- Throughput: one write per 2 cycles; one read per 2+READ_LAT cycles.

Test Plan:
- Reset, then x32 write addr=0x014, wdata=0xA1B2C3D4 -> cycle 1: csb/web all 0, addr_sram=0x05, din A..D = A1,B2,C3,D4, wr_ack=1; req_ready=1 in cycle 2.
- x32 read addr=0x014 (READ_LAT=1) -> cycle 1: csb all 0, web all 1; cycle 2: rd_valid=1, csb_out=1111; mux shows 0xA1B2C3D4.
- x8 reads at addr 0x014..0x017 -> masks 1000, 0100, 0010, 0001 in the rd_valid cycles; d_fabric[7:0] = A1, B2, C3, D4.
- x16 write addr=0x022, wdata=0x0000BEEF -> csb C, D = 0; din_C=BE, din_D=EF; A and B unselected with din 0; read back gives csb_out=0011 and d_fabric[15:0]=BEEF.
- x16 at addr=0x001, x32 at addr=0x002, and mode 3 -> err=1 in cycle 1, all csb=1, no wr_ack or rd_valid; req_ready=1 in cycle 2.
- READ_LAT=3 read with rst asserted in cycle 2 -> no rd_valid, all outputs at reset values in cycle 3; req_ready=1 after rst deasserts.

Source files
------------

// File: rtl/sram_cluster_ctrl.sv
// ----------------------------------------------------------------------------
// sram_cluster_ctrl : request-side controller for a 4-bank (A..D) x8 SRAM cluster
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sram_cluster_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_mode,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              csb_A,
  output logic              csb_B,
  output logic              csb_C,
  output logic              csb_D,
  output logic              web_A,
  output logic              web_B,
  output logic              web_C,
  output logic              web_D,
  output logic [ADDR_W-1:0] addr_sram,
  output logic [7:0]        din_A,
  output logic [7:0]        din_B,
  output logic [7:0]        din_C,
  output logic [7:0]        din_D,
  output logic              csb_out_A,
  output logic              csb_out_B,
  output logic              csb_out_C,
  output logic              csb_out_D,
  output logic              rd_valid,
  output logic              wr_ack,
  output logic              err
);

  localparam logic [2:0] LAT = 3'(READ_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic [3:0]        mask;
  logic              we_q, bad_q;
  logic [31:0]       lane_q;
  logic [ADDR_W-1:0] addr_q;

  logic        accept;
  logic [3:0]  mask_d;
  logic        bad_d;
  logic [31:0] lane_d;
  logic [31:0] lane_en;

  assign accept = req_valid & req_ready;

  // Lane mask {A,B,C,D} plus write data replicated so each lane sees its byte.
  always_comb begin
    mask_d = 4'b0000;
    bad_d  = 1'b0;
    lane_d = 32'd0;
    case (req_mode)
      2'd0: begin
        mask_d = 4'b1000 >> req_addr[1:0];
        lane_d = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        lane_d = {2{req_wdata[15:0]}};
        if (req_addr[0]) bad_d = 1'b1;
        else             mask_d = req_addr[1] ? 4'b0011 : 4'b1100;
      end
      2'd2: begin
        lane_d = req_wdata;
        if (req_addr[1:0] != 2'b00) bad_d = 1'b1;
        else                        mask_d = 4'b1111;
      end
      default: bad_d = 1'b1;
    endcase
    if (bad_d) mask_d = 4'b0000;
  end

  assign lane_en = {{8{mask_d[3]}}, {8{mask_d[2]}}, {8{mask_d[1]}}, {8{mask_d[0]}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      mask   <= 4'b0000;
      we_q   <= 1'b0;
      bad_q  <= 1'b0;
      lane_q <= 32'd0;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        mask   <= mask_d;
        we_q   <= req_we;
        bad_q  <= bad_d;
        lane_q <= lane_d & lane_en;
        addr_q <= req_addr[ADDR_W+1:2];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (accept) state_nxt = ISSUE;
      ISSUE: begin
        if (!bad_q && !we_q) begin
          state_nxt = WAIT;
          cnt_nxt   = LAT;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (cnt <= 3'd1) begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  logic        in_issue;
  logic        last_wait;
  logic [3:0]  csb_v, web_v, csb_out_v;
  logic [31:0] din_v;

  assign in_issue  = (state == ISSUE);
  assign last_wait = (state == WAIT) && (cnt == 3'd1);

  // Bank strobes stay live during a reset cycle so a coinciding write still lands.
  assign csb_v     = in_issue ? ~mask : 4'b1111;
  assign web_v     = (in_issue && we_q) ? ~mask : 4'b1111;
  assign din_v     = in_issue ? lane_q : 32'd0;

  assign req_ready = (state == IDLE) && !rst;
  assign rd_valid  = last_wait && !rst;
  assign wr_ack    = in_issue && we_q && !bad_q && !rst;
  assign err       = in_issue && bad_q && !rst;
  assign csb_out_v = rd_valid ? mask : 4'b0000;

  assign addr_sram = addr_q;
  assign {csb_A, csb_B, csb_C, csb_D} = csb_v;
  assign {web_A, web_B, web_C, web_D} = web_v;
  assign {din_A, din_B, din_C, din_D} = din_v;
  assign {csb_out_A, csb_out_B, csb_out_C, csb_out_D} = csb_out_v;

endmodule

`default_nettype wire

// File: tb/tb_sram_cluster_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sram_cluster_ctrl : directed bench with bank memory and output-mux models
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sram_cluster_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst3 = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_mode = 2'd0;
  logic [9:0]  req_addr = 10'd0;
  logic [31:0] req_wdata = 32'd0;

  logic req_ready, csb_A, csb_B, csb_C, csb_D, web_A, web_B, web_C, web_D;
  logic csb_out_A, csb_out_B, csb_out_C, csb_out_D, rd_valid, wr_ack, err;
  logic [7:0] addr_sram, din_A, din_B, din_C, din_D;

  logic ready3, c3A, c3B, c3C, c3D, w3A, w3B, w3C, w3D;
  logic o3A, o3B, o3C, o3D, rd_valid3, wr_ack3, err3;
  logic [7:0] addr3, d3A, d3B, d3C, d3D;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_cluster_ctrl #(.ADDR_W(8), .READ_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .csb_A(csb_A), .csb_B(csb_B), .csb_C(csb_C), .csb_D(csb_D),
    .web_A(web_A), .web_B(web_B), .web_C(web_C), .web_D(web_D),
    .addr_sram(addr_sram), .din_A(din_A), .din_B(din_B), .din_C(din_C), .din_D(din_D),
    .csb_out_A(csb_out_A), .csb_out_B(csb_out_B), .csb_out_C(csb_out_C), .csb_out_D(csb_out_D),
    .rd_valid(rd_valid), .wr_ack(wr_ack), .err(err)
  );

  sram_cluster_ctrl #(.ADDR_W(8), .READ_LAT(3)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(req_valid), .req_ready(ready3),
    .req_we(req_we), .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .csb_A(c3A), .csb_B(c3B), .csb_C(c3C), .csb_D(c3D),
    .web_A(w3A), .web_B(w3B), .web_C(w3C), .web_D(w3D),
    .addr_sram(addr3), .din_A(d3A), .din_B(d3B), .din_C(d3C), .din_D(d3D),
    .csb_out_A(o3A), .csb_out_B(o3B), .csb_out_C(o3C), .csb_out_D(o3D),
    .rd_valid(rd_valid3), .wr_ack(wr_ack3), .err(err3)
  );

  wire [3:0]  csb_v  = {csb_A, csb_B, csb_C, csb_D};
  wire [3:0]  web_v  = {web_A, web_B, web_C, web_D};
  wire [31:0] din_v  = {din_A, din_B, din_C, din_D};
  wire [3:0]  sel_v  = {csb_out_A, csb_out_B, csb_out_C, csb_out_D};
  wire [3:0]  csb3_v = {c3A, c3B, c3C, c3D};
  wire [3:0]  web3_v = {w3A, w3B, w3C, w3D};
  wire [31:0] din3_v = {d3A, d3B, d3C, d3D};
  wire [3:0]  sel3_v = {o3A, o3B, o3C, o3D};

  // Bank models: index 0..3 = A..D, dout holds the last read.
  logic [7:0] mem [4][256];
  logic [7:0] dout [4];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (!csb_v[3-b]) begin
        if (!web_v[3-b]) mem[b][addr_sram] <= din_v[31-8*b -: 8];
        else             dout[b] <= mem[b][addr_sram];
      end
    end
  end

  // Output mux: right-aligns the selected bank bytes onto d_fabric.
  logic [31:0] d_fabric;
  always_comb begin
    d_fabric = 32'd0;
    case (sel_v)
      4'b1111: d_fabric = {dout[0], dout[1], dout[2], dout[3]};
      4'b1100: d_fabric = {16'd0, dout[0], dout[1]};
      4'b0011: d_fabric = {16'd0, dout[2], dout[3]};
      4'b1000: d_fabric = {24'd0, dout[0]};
      4'b0100: d_fabric = {24'd0, dout[1]};
      4'b0010: d_fabric = {24'd0, dout[2]};
      4'b0001: d_fabric = {24'd0, dout[3]};
      default: d_fabric = 32'd0;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits for req_ready, presents one request and returns sampling in cycle 1.
  task automatic issue(input logic we, input logic [1:0] mode, input logic [9:0] addr,
                       input logic [31:0] wd);
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout: req_ready=%b required 1", req_ready);
    end
    req_we = we; req_mode = mode; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    checks++; if (csb_v !== 4'b1111) begin errors++; $display("FAIL rst_csb: got %b want 1111", csb_v); end
    checks++; if (web_v !== 4'b1111) begin errors++; $display("FAIL rst_web: got %b want 1111", web_v); end
    checks++; if (addr_sram !== 8'h00) begin errors++; $display("FAIL rst_addr: got %h want 00", addr_sram); end
    checks++; if (din_v !== 32'd0) begin errors++; $display("FAIL rst_din: got %h want 0", din_v); end
    checks++; if ({sel_v, rd_valid, wr_ack, err, req_ready} !== 8'd0) begin
      errors++; $display("FAIL rst_flags: got %b want 00000000", {sel_v, rd_valid, wr_ack, err, req_ready});
    end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_write32;
    issue(1'b1, 2'd2, 10'h014, 32'hA1B2C3D4);
    checks++; if (csb_v !== 4'b0000 || web_v !== 4'b0000) begin
      errors++; $display("FAIL w32_strobes: csb=%b web=%b want 0000/0000", csb_v, web_v);
    end
    checks++; if (addr_sram !== 8'h05) begin errors++; $display("FAIL w32_addr: got %h want 05", addr_sram); end
    checks++; if (din_v !== 32'hA1B2C3D4) begin errors++; $display("FAIL w32_din: got %h want a1b2c3d4", din_v); end
    checks++; if ({wr_ack, rd_valid, err} !== 3'b100) begin
      errors++; $display("FAIL w32_pulse: wr_ack/rd_valid/err=%b want 100", {wr_ack, rd_valid, err});
    end
    tick();
    checks++; if ({req_ready, wr_ack, csb_v} !== 6'b101111) begin
      errors++; $display("FAIL w32_cycle2: ready/ack/csb=%b want 101111", {req_ready, wr_ack, csb_v});
    end
  endtask

  task automatic test_read32;
    issue(1'b0, 2'd2, 10'h014, 32'd0);
    checks++; if (csb_v !== 4'b0000 || web_v !== 4'b1111 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL r32_cycle1: csb=%b web=%b rd_valid=%b want 0000/1111/0", csb_v, web_v, rd_valid);
    end
    tick();
    checks++; if (rd_valid !== 1'b1 || sel_v !== 4'b1111) begin
      errors++; $display("FAIL r32_valid: rd_valid=%b csb_out=%b want 1/1111", rd_valid, sel_v);
    end
    checks++; if (d_fabric !== 32'hA1B2C3D4) begin errors++; $display("FAIL r32_data: got %h want a1b2c3d4", d_fabric); end
    tick();
    checks++; if ({req_ready, rd_valid, sel_v} !== 6'b100000) begin
      errors++; $display("FAIL r32_cycle3: ready/rd_valid/csb_out=%b want 100000", {req_ready, rd_valid, sel_v});
    end
  endtask

  task automatic test_read8;
    logic [31:0] word;
    logic [3:0]  want_sel;
    word = 32'hA1B2C3D4;
    for (int i = 0; i < 4; i++) begin
      want_sel = 4'b1000 >> i;
      issue(1'b0, 2'd0, 10'h014 + 10'(i), 32'd0);
      checks++; if (csb_v !== ~want_sel) begin errors++; $display("FAIL r8_csb[%0d]: got %b want %b", i, csb_v, ~want_sel); end
      tick();
      checks++; if (rd_valid !== 1'b1 || sel_v !== want_sel) begin
        errors++; $display("FAIL r8_sel[%0d]: rd_valid=%b csb_out=%b want 1/%b", i, rd_valid, sel_v, want_sel);
      end
      checks++; if (d_fabric[7:0] !== word[31-8*i -: 8]) begin
        errors++; $display("FAIL r8_data[%0d]: got %h want %h", i, d_fabric[7:0], word[31-8*i -: 8]);
      end
    end
  endtask

  task automatic test_write16;
    issue(1'b1, 2'd1, 10'h022, 32'h0000BEEF);
    checks++; if (csb_v !== 4'b1100 || web_v !== 4'b1100) begin
      errors++; $display("FAIL w16_strobes: csb=%b web=%b want 1100/1100", csb_v, web_v);
    end
    checks++; if (din_v !== 32'h0000BEEF || addr_sram !== 8'h08) begin
      errors++; $display("FAIL w16_din: din=%h addr=%h want 0000beef/08", din_v, addr_sram);
    end
    checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL w16_ack: got %b want 1", wr_ack); end
    tick();
    issue(1'b0, 2'd1, 10'h022, 32'd0);
    tick();
    checks++; if (rd_valid !== 1'b1 || sel_v !== 4'b0011 || d_fabric[15:0] !== 16'hBEEF) begin
      errors++; $display("FAIL r16_back: rd_valid=%b csb_out=%b data=%h want 1/0011/beef", rd_valid, sel_v, d_fabric[15:0]);
    end
  endtask

  task automatic test_illegal;
    logic [1:0] modes [3];
    logic [9:0] addrs [3];
    modes[0] = 2'd1; addrs[0] = 10'h001;
    modes[1] = 2'd2; addrs[1] = 10'h002;
    modes[2] = 2'd3; addrs[2] = 10'h000;
    for (int i = 0; i < 3; i++) begin
      issue(1'(i % 2), modes[i], addrs[i], 32'hFFFFFFFF);
      checks++; if ({err, wr_ack, rd_valid, req_ready} !== 4'b1000) begin
        errors++; $display("FAIL ill_pulse[%0d]: err/ack/rv/ready=%b want 1000", i, {err, wr_ack, rd_valid, req_ready});
      end
      checks++; if (csb_v !== 4'b1111 || web_v !== 4'b1111 || din_v !== 32'd0) begin
        errors++; $display("FAIL ill_banks[%0d]: csb=%b web=%b din=%h want 1111/1111/0", i, csb_v, web_v, din_v);
      end
      tick();
      checks++; if ({req_ready, err, rd_valid} !== 3'b100) begin
        errors++; $display("FAIL ill_cycle2[%0d]: ready/err/rv=%b want 100", i, {req_ready, err, rd_valid});
      end
    end
  endtask

  task automatic test_back_to_back;
    issue(1'b1, 2'd0, 10'h030, 32'h00000055);
    // second request presented while busy; must not be taken until cycle 2
    req_we = 1'b1; req_mode = 2'd0; req_addr = 10'h031; req_wdata = 32'h00000066; req_valid = 1'b1;
    checks++; if (csb_v !== 4'b0111 || din_v !== 32'h55000000 || wr_ack !== 1'b1) begin
      errors++; $display("FAIL b2b_first: csb=%b din=%h ack=%b want 0111/55000000/1", csb_v, din_v, wr_ack);
    end
    tick();
    checks++; if ({req_ready, wr_ack, csb_v} !== 6'b101111) begin
      errors++; $display("FAIL b2b_gap: ready/ack/csb=%b want 101111", {req_ready, wr_ack, csb_v});
    end
    tick();
    req_valid = 1'b0;
    checks++; if (csb_v !== 4'b1011 || din_v !== 32'h00660000 || addr_sram !== 8'h0C || wr_ack !== 1'b1) begin
      errors++; $display("FAIL b2b_second: csb=%b din=%h addr=%h ack=%b want 1011/00660000/0c/1", csb_v, din_v, addr_sram, wr_ack);
    end
    tick();
  endtask

  task automatic test_lat3_reset;
    checks++; if (ready3 !== 1'b0 || csb3_v !== 4'b1111) begin
      errors++; $display("FAIL l3_held: ready=%b csb=%b want 0/1111", ready3, csb3_v);
    end
    rst3 = 1'b0;
    #1;
    checks++; if (ready3 !== 1'b1) begin errors++; $display("FAIL l3_ready: got %b want 1", ready3); end
    req_we = 1'b0; req_mode = 2'd2; req_addr = 10'h014; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    checks++; if (csb3_v !== 4'b0000 || web3_v !== 4'b1111) begin
      errors++; $display("FAIL l3_issue: csb=%b web=%b want 0000/1111", csb3_v, web3_v);
    end
    for (int c = 2; c <= 3; c++) begin
      tick();
      checks++; if (rd_valid3 !== 1'b0) begin errors++; $display("FAIL l3_early[%0d]: rd_valid=%b want 0", c, rd_valid3); end
    end
    tick();
    checks++; if (rd_valid3 !== 1'b1 || sel3_v !== 4'b1111) begin
      errors++; $display("FAIL l3_valid: rd_valid=%b csb_out=%b want 1/1111", rd_valid3, sel3_v);
    end
    tick();
    checks++; if (ready3 !== 1'b1 || rd_valid3 !== 1'b0) begin
      errors++; $display("FAIL l3_done: ready=%b rd_valid=%b want 1/0", ready3, rd_valid3);
    end
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rst3 = 1'b1;
    #1;
    checks++; if (rd_valid3 !== 1'b0) begin errors++; $display("FAIL l3_rst_c2: rd_valid=%b want 0", rd_valid3); end
    tick();
    checks++; if ({csb3_v, web3_v, sel3_v, rd_valid3, wr_ack3, err3, ready3} !== 16'hFF00) begin
      errors++; $display("FAIL l3_rst_flags: got %b want 1111111100000000", {csb3_v, web3_v, sel3_v, rd_valid3, wr_ack3, err3, ready3});
    end
    checks++; if (addr3 !== 8'h00 || din3_v !== 32'd0) begin
      errors++; $display("FAIL l3_rst_data: addr=%h din=%h want 00/0", addr3, din3_v);
    end
    rst3 = 1'b0;
    #1;
    checks++; if (ready3 !== 1'b1) begin errors++; $display("FAIL l3_rst_release: ready=%b want 1", ready3); end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (rd_valid3 !== 1'b0) begin errors++; $display("FAIL l3_ghost[%0d]: rd_valid=%b want 0", c, rd_valid3); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_write32();
    test_read32();
    test_read8();
    test_write16();
    test_illegal();
    test_back_to_back();
    test_lat3_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
